rtc_read_cycle: RTL and testbench
=================================

// Module: rtc_read_cycle
// PURPOSE
//  Bus master for one read transaction on the multiplexed RTC bus (AD, CS, WR, RD, 8-bit data).
//  Phase 1 drives the register address with AD=0 and a WR strobe; phase 2 reads data with AD=1
//  and an RD strobe, then samples the bus. Read-side counterpart of the RTC write-cycle FSM.
//  Driven by the RTC controller; shares the bus pins through bus_oe.
// PARAMETERS
//  T_AS    10  cycles AD=0 before CS falls (address phase setup)
//  T_CS    10  cycles CS=0 before strobe (used in both phases)
//  T_WR    50  cycles WR=0 with address driven
//  T_HOLD  10  cycles after strobe rises, before the next phase (used in both phases)
//  T_GAP   10  cycles bus released, AD=1, CS=1 between phases
//  T_RD    30  cycles RD=0; bus sampled on last cycle
//  CNT_W   9   phase-counter width; every T_x must satisfy 1 <= T_x <= 2^CNT_W-1
// PORTS
//  clk         in   1  clock
//  reset       in   1  asynchronous, active-high
//  start       in   1  request; accepted only in IDLE
//  addr        in   8  register address; latched when start is accepted
//  bus_in      in   8  data bus from pad
//  bus_out     out  8  data bus to pad (latched addr)
//  bus_oe      out  1  1 = drive bus_out onto pad
//  ad          out  1  0 = address phase, idle 1
//  cs_n        out  1  chip select, active-low, idle 1
//  wr_n        out  1  write strobe, active-low, idle 1
//  rd_n        out  1  read strobe, active-low, idle 1
//  data_out    out  8  last sampled read data; held until the next sample
//  data_valid  out  1  1-cycle pulse when data_out updates
//  busy        out  1  1 whenever state != IDLE
// BEHAVIOUR
//  - All outputs are registered Moore outputs of state; no combinational paths from inputs.
//  - Reset values: ad=1, cs_n=1, wr_n=1, rd_n=1, bus_oe=0, bus_out=0, data_out=0,
//    data_valid=0, busy=0, state=IDLE.
//  - Reset mid-transaction: all outputs return to reset values immediately; the transaction is dropped.
//  - Each timed state lasts exactly T_x cycles. Phase counter loads on state entry; exit on count T_x-1.
//  - States and outputs (ad, cs_n, wr_n, rd_n, oe), in order:
//    - IDLE  (1,1,1,1,0): start=1 -> AS; addr -> addr_q.
//    - AS    (0,1,1,1,0): T_AS -> ACS.
//    - ACS   (0,0,1,1,1): T_CS -> AWR.
//    - AWR   (0,0,0,1,1): T_WR -> AHOLD.
//    - AHOLD (0,1,1,1,1): T_HOLD -> GAP.
//    - GAP   (1,1,1,1,0): T_GAP -> DCS.
//    - DCS   (1,0,1,1,0): T_CS -> DRD.
//    - DRD   (1,0,1,0,0): T_RD -> DREL; data_out <= bus_in on the exit edge.
//    - DREL  (1,0,1,1,0): T_HOLD -> DONE.
//    - DONE  (1,1,1,1,0), data_valid=1: 1 cycle -> IDLE.
//  - Latency: start accepted at edge k -> data_valid high in cycle k+141 with default parameters
//    (sum of all T_x + 1). busy is high for the same 141 cycles.
//  - start while busy is ignored; it is not queued. start held high in IDLE starts back-to-back reads.
//  - bus_oe is low for at least T_GAP+T_CS cycles before rd_n falls: no contention.
//  - The latched address does not change during a transaction, even if addr toggles.
// STRUCTURE
//  - rtc_bus_pkg: state enum (4-bit), idle levels of the control pins, default timing constants;
//    shared with the write-cycle FSM.
//  - Sub-module phase_timer: load/count/terminal-count counter, CNT_W wide, with T_x selected by state.
//  - Top level: state register, output registers, addr_q and data_out registers.
// TESTING
//  1. Reset, then idle 20 cycles -> all outputs at reset values; busy=0.
//  2. start=1 for 1 cycle with addr=0x24; pad model returns 0x5A while rd_n=0 ->
//     bus_out=0x24 with oe=1 only in ACS/AWR/AHOLD; data_out=0x5A; data_valid at +141.
//  3. Check every strobe edge against the parameter table, e.g. wr_n low for exactly 50 cycles
//     and rd_n low for exactly 30; no cycle with oe=1 && rd_n=0.
//  4. Pulse start again mid-transaction (addr=0x99) -> ignored; transaction completes with
//     address 0x24; exactly one data_valid.
//  5. Assert reset during DRD -> outputs return to idle at once, data_valid is never pulsed;
//     a new start runs a clean full cycle.
//  6. Hold start high, with data changing 0x11 -> 0x22 -> two back-to-back reads;
//     data_valid pulses 142 cycles apart; data_out = 0x11 then 0x22.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared state encoding, pin levels and default timings for the RTC bus FSMs
package rtc_bus_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_AS, S_ACS, S_AWR, S_AHOLD, S_GAP, S_DCS, S_DRD, S_DREL, S_DONE
  } state_e;
  typedef struct packed {
    logic ad;
    logic cs_n;
    logic wr_n;
    logic rd_n;
    logic oe;
  } pins_t;
  localparam pins_t PINS_IDLE = '{ad: 1'b1, cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, oe: 1'b0};
  localparam int T_AS_DEF   = 10;
  localparam int T_CS_DEF   = 10;
  localparam int T_WR_DEF   = 50;
  localparam int T_HOLD_DEF = 10;
  localparam int T_GAP_DEF  = 10;
  localparam int T_RD_DEF   = 30;
  localparam int CNT_W_DEF  = 9;
  // Pin levels {ad, cs_n, wr_n, rd_n, oe} held while in each state
  function automatic pins_t pins_of(state_e s);
    case (s)
      S_AS:    return pins_t'(5'b01110);
      S_ACS:   return pins_t'(5'b00111);
      S_AWR:   return pins_t'(5'b00011);
      S_AHOLD: return pins_t'(5'b01111);
      S_DCS:   return pins_t'(5'b10110);
      S_DRD:   return pins_t'(5'b10100);
      S_DREL:  return pins_t'(5'b10110);
      default: return PINS_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-state cycle counter, restarts on state entry and flags the last cycle
//   clk, reset      clock, async active-high reset
//   state_i         current FSM state, selects the phase length
//   load_i          1 on the edge that enters a new state
//   tc_o            1 during the last cycle of the current phase
module phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int T_AS   = T_AS_DEF,
  parameter int T_CS   = T_CS_DEF,
  parameter int T_WR   = T_WR_DEF,
  parameter int T_HOLD = T_HOLD_DEF,
  parameter int T_GAP  = T_GAP_DEF,
  parameter int T_RD   = T_RD_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  state_e state_i,
  input  logic   load_i,
  output logic   tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, term;
  always_comb begin
    case (state_i)
      S_AS:           term = CNT_W'(T_AS - 1);
      S_ACS, S_DCS:   term = CNT_W'(T_CS - 1);
      S_AWR:          term = CNT_W'(T_WR - 1);
      S_AHOLD, S_DREL: term = CNT_W'(T_HOLD - 1);
      S_GAP:          term = CNT_W'(T_GAP - 1);
      S_DRD:          term = CNT_W'(T_RD - 1);
      default:        term = '0;
    endcase
    cnt_d = load_i ? '0 : cnt_q + CNT_W'(1);
  end
  assign tc_o = cnt_q == term;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/rtc_read_cycle.sv
// rtc_read_cycle: bus master for one address-then-read transaction on the multiplexed RTC bus
//   start_i/addr_i   request and register address (accepted only when idle)
//   bus_in_i         pad data, sampled on the last RD-low cycle
//   bus_out_o/oe_o   latched address and its pad drive enable
//   ad/cs_n/wr_n/rd_n bus control pins
//   data_out_o       last read data, data_valid_o pulses for one cycle after each read
//   busy_o           high whenever a transaction is in progress
module rtc_read_cycle
  import rtc_bus_pkg::*;
#(
  parameter int T_AS   = T_AS_DEF,
  parameter int T_CS   = T_CS_DEF,
  parameter int T_WR   = T_WR_DEF,
  parameter int T_HOLD = T_HOLD_DEF,
  parameter int T_GAP  = T_GAP_DEF,
  parameter int T_RD   = T_RD_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] bus_in_i,
  output logic [7:0] bus_out_o,
  output logic       bus_oe_o,
  output logic       ad_o,
  output logic       cs_n_o,
  output logic       wr_n_o,
  output logic       rd_n_o,
  output logic [7:0] data_out_o,
  output logic       data_valid_o,
  output logic       busy_o
);
  state_e     state_q, state_d;
  pins_t      pins_q;
  logic [7:0] addr_q, data_q;
  logic       busy_q, dv_q, tc;
  phase_timer #(
    .CNT_W(CNT_W), .T_AS(T_AS), .T_CS(T_CS), .T_WR(T_WR),
    .T_HOLD(T_HOLD), .T_GAP(T_GAP), .T_RD(T_RD)
  ) u_timer (
    .clk(clk),
    .reset(reset),
    .state_i(state_q),
    .load_i(state_d != state_q),
    .tc_o(tc)
  );
  // Timed states are enumerated in bus order, so a finished phase just steps to the next code
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) state_d = start_i ? S_AS : S_IDLE;
    else if (state_q == S_DONE) state_d = S_IDLE;
    else if (tc) state_d = state_e'(state_q + 4'd1);
  end
  // Outputs are decoded from the next state so they switch on the same edge as the state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      pins_q  <= PINS_IDLE;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pins_q  <= pins_of(state_d);
      busy_q  <= state_d != S_IDLE;
      dv_q    <= state_d == S_DONE;
      addr_q  <= (state_q == S_IDLE && start_i) ? addr_i : addr_q;
      data_q  <= (state_q == S_DRD && tc) ? bus_in_i : data_q;
    end
  assign bus_out_o    = addr_q;
  assign bus_oe_o     = pins_q.oe;
  assign ad_o         = pins_q.ad;
  assign cs_n_o       = pins_q.cs_n;
  assign wr_n_o       = pins_q.wr_n;
  assign rd_n_o       = pins_q.rd_n;
  assign data_out_o   = data_q;
  assign data_valid_o = dv_q;
  assign busy_o       = busy_q;
endmodule

// File: tb/tb_rtc_read_cycle.sv
// tb_rtc_read_cycle: randomized self-checking bench against a phase-table model of the read cycle
module tb_rtc_read_cycle;
  localparam logic [6:0] IDLE_V = 7'b0011110;
  logic       clk = 0, reset = 1, start = 0;
  logic [7:0] addr = 0, pad = 0, bus_in, bus_out, data_out;
  logic       bus_oe, ad, cs_n, wr_n, rd_n, dv, busy;
  int         n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  // Pad drives the read data only while RD is low, garbage otherwise
  assign bus_in = rd_n ? ~pad : pad;
  rtc_read_cycle dut (
    .clk(clk), .reset(reset), .start_i(start), .addr_i(addr), .bus_in_i(bus_in),
    .bus_out_o(bus_out), .bus_oe_o(bus_oe), .ad_o(ad), .cs_n_o(cs_n), .wr_n_o(wr_n),
    .rd_n_o(rd_n), .data_out_o(data_out), .data_valid_o(dv), .busy_o(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] obs();
    return {busy, dv, ad, cs_n, wr_n, rd_n, bus_oe};
  endfunction
  // Expected {busy,dv,ad,cs_n,wr_n,rd_n,oe} for cycle i after the accepting edge
  function automatic logic [6:0] exp_vec(int i);
    int         dur[9] = '{10, 10, 50, 10, 10, 10, 30, 10, 1};
    logic [4:0] pin[9] = '{5'b01110, 5'b00111, 5'b00011, 5'b01111, 5'b11110,
                           5'b10110, 5'b10100, 5'b10110, 5'b11110};
    int acc = 0;
    for (int p = 0; p < 9; p++) begin
      if (i < acc + dur[p]) return {1'b1, 1'(p == 8), pin[p]};
      acc += dur[p];
    end
    return IDLE_V;
  endfunction
  task automatic run_txn(input logic [7:0] a, input logic [7:0] d, input bit noise);
    int wr_lo = 0, rd_lo = 0, dvs = 0;
    start = 1; addr = a; pad = d;
    @(negedge clk);
    for (int i = 0; i < 141; i++) begin
      check("pins", obs(), exp_vec(i));
      if (bus_oe) check("bus_out", bus_out, a);
      check("contention", bus_oe & ~rd_n, 0);
      wr_lo += int'(!wr_n);
      rd_lo += int'(!rd_n);
      dvs += int'(dv);
      start = noise && (i == 50 || $urandom_range(7) == 0);
      addr = noise ? (i == 50 ? 8'h99 : 8'($urandom)) : a;
      @(negedge clk);
    end
    start = 0;
    check("wr_low", wr_lo, 50);
    check("rd_low", rd_lo, 30);
    check("dv_count", dvs, 1);
    check("data_out", data_out, d);
    check("idle_after", obs(), IDLE_V);
  endtask
  initial begin
    int dvs, t1, t2;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (20) @(negedge clk);
    check("reset_pins", obs(), IDLE_V);
    check("reset_bus_out", bus_out, 0);
    check("reset_data", data_out, 0);
    run_txn(8'h24, 8'h5A, 0);
    run_txn(8'h24, 8'hC3, 1);
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(5)) @(negedge clk);
      run_txn(8'($urandom), 8'($urandom), 1'($urandom_range(1)));
    end
    start = 1; addr = 8'h3C; pad = 8'h77;
    @(negedge clk);
    start = 0;
    repeat (115) @(negedge clk);
    check("in_drd", {rd_n, bus_oe}, 2'b00);
    reset = 1;
    #1;
    check("rst_async_pins", obs(), IDLE_V);
    check("rst_async_data", data_out, 0);
    check("rst_async_addr", bus_out, 0);
    repeat (3) @(negedge clk);
    reset = 0;
    dvs = 0;
    repeat (40) begin
      @(negedge clk);
      dvs += int'(dv);
    end
    check("no_dv_after_rst", dvs, 0);
    check("idle_after_rst", obs(), IDLE_V);
    run_txn(8'hA5, 8'h3E, 0);
    start = 1; addr = 8'h42; pad = 8'h11;
    t1 = -1; t2 = -1;
    for (int c = 0; c < 400 && t2 < 0; c++) begin
      @(negedge clk);
      if (dv && t1 < 0) begin
        t1 = c;
        check("b2b_data1", data_out, 8'h11);
        pad = 8'h22;
      end else if (dv) begin
        t2 = c;
        check("b2b_data2", data_out, 8'h22);
      end
    end
    start = 0;
    check("b2b_spacing", t2 - t1, 142);
    repeat (2) @(negedge clk);
    check("b2b_idle", obs(), IDLE_V);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
